// File: rtl/regfile_bypass.sv
// Register file with byte-enable writes, a dedicated link-register write port,
// optional same-cycle forwarding and per-register pending-load scoreboard.
module regfile_bypass #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int LINK_REG = 31,
   parameter int BYPASS   = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_W-1:0]     rd_addr1,
   input  logic [ADDR_W-1:0]     rd_addr2,
   output logic [DATA_W-1:0]     rd_data1,
   output logic [DATA_W-1:0]     rd_data2,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_be,
   input  logic                  link_en,
   input  logic [DATA_W-1:0]     link_data,
   input  logic                  busy_set,
   input  logic [ADDR_W-1:0]     busy_addr,
   output logic                  stall,
   output logic [ADDR_W:0]       pending_cnt,
   input  logic [ADDR_W-1:0]     dbg_addr,
   output logic [DATA_W-1:0]     dbg_data
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NBYTE = DATA_W/8;
   localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);

   logic [DATA_W-1:0] regs   [DEPTH];
   logic [DATA_W-1:0] regs_n [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_n;
   logic [DEPTH-1:0]  clr_hit;
   logic [ADDR_W:0]   cnt_n;

   // regs_n is the post-edge image of every register; it doubles as the
   // forwarding source, so bypass and storage can never disagree.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         regs_n[i]  = regs[i];
         clr_hit[i] = 1'b0;
         busy_n[i]  = 1'b0;
         if (i != 0) begin
            if (wr_en && (wr_addr == ADDR_W'(i))) begin
               clr_hit[i] = 1'b1;
               for (int b = 0; b < NBYTE; b++) begin
                  if (wr_be[b]) begin
                     regs_n[i][8*b +: 8] = wr_data[8*b +: 8];
                  end
               end
            end
            // Link write applied last so it overrides every byte of a colliding write.
            if (link_en && (LINK_A == ADDR_W'(i))) begin
               clr_hit[i] = 1'b1;
               regs_n[i]  = link_data;
            end
            busy_n[i] = (busy[i] & ~clr_hit[i]) |
                        (busy_set && (busy_addr == ADDR_W'(i)));
         end
      end
   end

   always_comb begin
      cnt_n = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cnt_n = cnt_n + (ADDR_W+1)'(busy_n[i]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         busy        <= '0;
         pending_cnt <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= regs_n[i];
         end
         busy        <= busy_n;
         pending_cnt <= cnt_n;
      end
   end

   // Outputs are forced quiet during reset so in-flight write data cannot leak through.
   always_comb begin
      rd_data1 = '0;
      rd_data2 = '0;
      dbg_data = '0;
      stall    = 1'b0;
      if (!reset) begin
         if (BYPASS != 0) begin
            rd_data1 = regs_n[rd_addr1];
            rd_data2 = regs_n[rd_addr2];
         end else begin
            rd_data1 = regs[rd_addr1];
            rd_data2 = regs[rd_addr2];
         end
         dbg_data = regs[dbg_addr];
         stall    = ((rd_addr1 != '0) && busy[rd_addr1] && !clr_hit[rd_addr1]) ||
                    ((rd_addr2 != '0) && busy[rd_addr2] && !clr_hit[rd_addr2]);
      end
   end

endmodule

// File: tb/tb_regfile_bypass.sv
// Randomized plus directed bench for regfile_bypass against an array-based
// reference model of the register/scoreboard rules.
module tb_regfile_bypass;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NR   = 32;
   localparam int LINK = 31;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, busy_addr, dbg_addr;
   logic [DW-1:0] rd_data1, rd_data2, wr_data, link_data, dbg_data;
   logic [DW/8-1:0] wr_be;
   logic          wr_en, link_en, busy_set, stall;
   logic [AW:0]   pending_cnt;

   regfile_bypass #(.DATA_W(DW), .ADDR_W(AW), .LINK_REG(LINK), .BYPASS(1)) dut (
      .clk(clk), .reset(reset),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .link_en(link_en), .link_data(link_data),
      .busy_set(busy_set), .busy_addr(busy_addr),
      .stall(stall), .pending_cnt(pending_cnt),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] mr [NR];
   bit            mb [NR];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit written(int a);
      return (a != 0) && ((wr_en && (int'(wr_addr) == a)) || (link_en && (a == LINK)));
   endfunction

   function automatic logic [DW-1:0] post(int a);
      logic [DW-1:0] v;
      if (a == 0) return '0;
      v = mr[a];
      if (wr_en && (int'(wr_addr) == a))
         for (int b = 0; b < DW/8; b++)
            if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
      if (link_en && (a == LINK)) v = link_data;
      return v;
   endfunction

   function automatic bit exp_stall();
      int a1 = int'(rd_addr1);
      int a2 = int'(rd_addr2);
      return (a1 != 0 && mb[a1] && !written(a1)) || (a2 != 0 && mb[a2] && !written(a2));
   endfunction

   function automatic int popcnt();
      int n = 0;
      for (int i = 0; i < NR; i++) n += int'(mb[i]);
      return n;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NR; i++) begin
         mr[i] = '0;
         mb[i] = 1'b0;
      end
   endtask

   task automatic idle();
      wr_en = 1'b0; link_en = 1'b0; busy_set = 1'b0; wr_be = '0;
   endtask

   // Check combinational outputs, cross one edge, update model, check pending_cnt.
   task automatic step();
      logic [DW-1:0] nr [NR];
      bit            nb [NR];
      #1;
      if (reset) begin
         chk("rst_rd1", rd_data1, 0);
         chk("rst_rd2", rd_data2, 0);
         chk("rst_stall", stall, 0);
         chk("rst_dbg", dbg_data, 0);
      end else begin
         chk("rd1", rd_data1, post(int'(rd_addr1)));
         chk("rd2", rd_data2, post(int'(rd_addr2)));
         chk("stall", stall, exp_stall());
         chk("dbg", dbg_data, mr[dbg_addr]);
      end
      @(posedge clk);
      if (reset) begin
         clear_model();
      end else begin
         for (int a = 0; a < NR; a++) begin
            nr[a] = post(a);
            nb[a] = mb[a];
            if (written(a)) nb[a] = 1'b0;
            if (busy_set && int'(busy_addr) == a && a != 0) nb[a] = 1'b1;
         end
         for (int a = 0; a < NR; a++) begin
            mr[a] = nr[a];
            mb[a] = nb[a];
         end
      end
      #1;
      chk("pend", pending_cnt, popcnt());
   endtask

   function automatic logic [AW-1:0] ra();
      case ($urandom % 4)
         0: return AW'(LINK);
         1: return AW'($urandom % NR);
         default: return AW'($urandom % 8);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clear_model();
      reset = 1'b1;
      idle();
      rd_addr1 = '0; rd_addr2 = '0; wr_addr = '0; busy_addr = '0; dbg_addr = '0;
      wr_data = '0; link_data = '0;

      // Activity during reset must be discarded and not forwarded.
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 5; wr_be = '1; wr_data = 32'hDEAD_BEEF;
      link_en = 1'b1; link_data = 32'hCAFE_F00D;
      busy_set = 1'b1; busy_addr = 6;
      rd_addr1 = 5; rd_addr2 = 31; dbg_addr = 5;
      step();
      reset = 1'b0;
      idle();

      for (int i = 0; i < NR; i++) begin
         rd_addr1 = AW'(i); rd_addr2 = AW'(NR-1-i); dbg_addr = AW'(i);
         #1;
         chk("init_rd1", rd_data1, 0);
         chk("init_rd2", rd_data2, 0);
         chk("init_dbg", dbg_data, 0);
         chk("init_stall", stall, 0);
      end
      chk("init_pend", pending_cnt, 0);

      // Byte-enable merge
      wr_en = 1'b1; wr_addr = 5; wr_be = 4'b1111; wr_data = 32'hAABB_CCDD; rd_addr1 = 5;
      step();
      wr_data = 32'h1122_3344; wr_be = 4'b0101;
      step();
      idle(); dbg_addr = 5; #1;
      chk("be_merge", dbg_data, 32'hAA22_CC44);

      // Link beats general write to the same register, and is forwarded
      wr_en = 1'b1; wr_addr = 31; wr_be = '1; wr_data = 32'h0000_1234;
      link_en = 1'b1; link_data = 32'h0040_0008; rd_addr1 = 31; #1;
      chk("link_byp", rd_data1, 32'h0040_0008);
      step();
      idle(); dbg_addr = 31; #1;
      chk("link_store", dbg_data, 32'h0040_0008);

      // Pending load and stall
      busy_set = 1'b1; busy_addr = 7;
      step();
      idle(); rd_addr2 = 7; rd_addr1 = 0; #1;
      chk("busy_stall", stall, 1);
      chk("busy_pend", pending_cnt, 1);
      step();
      wr_en = 1'b1; wr_addr = 7; wr_be = '1; wr_data = 32'h77; #1;
      chk("clr_stall", stall, 0);
      step();
      chk("clr_pend", pending_cnt, 0);

      // New load wins over a same-cycle clearing write; r0 never pending
      idle(); busy_set = 1'b1; busy_addr = 9; wr_en = 1'b1; wr_addr = 9; wr_be = '1; wr_data = 32'h99;
      step();
      chk("set_wins", pending_cnt, 1);
      idle(); busy_set = 1'b1; busy_addr = 0;
      step();
      chk("r0_busy", pending_cnt, 1);
      busy_addr = 9;
      step();
      chk("rebusy", pending_cnt, 1);
      idle(); rd_addr1 = 9; rd_addr2 = 0; #1;
      chk("r9_stall", stall, 1);
      wr_en = 1'b1; wr_addr = 0; wr_be = '1; wr_data = 32'hFFFF_FFFF; rd_addr1 = 0;
      step();
      idle(); dbg_addr = 0; #1;
      chk("r0_zero", dbg_data, 0);

      for (int n = 0; n < 1500; n++) begin
         wr_en     = ($urandom % 2) == 0;
         wr_addr   = ra();
         wr_be     = 4'($urandom);
         wr_data   = $urandom;
         link_en   = ($urandom % 4) == 0;
         link_data = $urandom;
         busy_set  = ($urandom % 3) == 0;
         busy_addr = ra();
         rd_addr1  = ($urandom % 2) ? wr_addr : ra();
         rd_addr2  = ($urandom % 2) ? busy_addr : ra();
         dbg_addr  = ($urandom % 2) ? wr_addr : ra();
         step();
      end

      // Asynchronous reset between edges
      idle();
      wr_en = 1'b1; wr_addr = 3; wr_be = '1; wr_data = 32'h5A5A_5A5A; busy_set = 1'b1; busy_addr = 3;
      step();
      idle(); rd_addr1 = 3; rd_addr2 = 0; dbg_addr = 3; #1;
      chk("pre_rst_stall", stall, 1);
      chk("pre_rst_dbg", dbg_data, 32'h5A5A_5A5A);
      #1;
      reset = 1'b1;
      clear_model();
      #1;
      chk("arst_rd1", rd_data1, 0);
      chk("arst_stall", stall, 0);
      chk("arst_pend", pending_cnt, 0);
      chk("arst_dbg", dbg_data, 0);
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = 3; wr_be = '1; wr_data = 32'h1357_9BDF; busy_set = 1'b1; busy_addr = 4;
      step();
      reset = 1'b0;
      idle(); #1;
      chk("post_rst_dbg", dbg_data, 0);
      chk("post_rst_pend", pending_cnt, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 Parameter DATA_W, default 32: register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 5: address width; depth = 2**ADDR_W registers.
REQ-003 Parameter LINK_REG, default 31: index written by the link port.
REQ-004 Parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-007 rd_addr1, rd_addr2  input  ADDR_W  read port addresses.
REQ-008 rd_data1, rd_data2  output  DATA_W  combinational read data.
REQ-009 wr_en  input  1  general write strobe.
REQ-010 wr_addr  input  ADDR_W  general write address.
REQ-011 wr_data  input  DATA_W  general write data.
REQ-012 wr_be  input  DATA_W/8  byte enables for the general write; bit i covers byte i.
REQ-013 link_en  input  1  full-word write of link_data to LINK_REG.
REQ-014 link_data  input  DATA_W  link (return-address) value.
REQ-015 busy_set  input  1  marks busy_addr pending (load issued, result not yet written).
REQ-016 busy_addr  input  ADDR_W  register to mark pending.
REQ-017 stall  output  1  combinational: a read port addresses a pending register.
REQ-018 pending_cnt  output  ADDR_W+1  number of registers currently pending.
REQ-019 dbg_addr  input  ADDR_W; dbg_data  output  DATA_W  debug read port (non-forwarded).

Function
REQ-020 Register 0 SHALL always read 0; writes, link writes and busy_set to index 0 SHALL be ignored.
REQ-021 On a rising edge with wr_en=1, only bytes whose wr_be bit is 1 SHALL update; other bytes SHALL keep their value.
REQ-022 wr_en=1 with wr_be all zero SHALL leave data unchanged but still clear the busy bit of wr_addr.
REQ-023 link_en=1 SHALL write all DATA_W bits of LINK_REG; with wr_en=1 to the same address in the same cycle, the link write SHALL win for every byte.
REQ-024 link_en and wr_en to different addresses in the same cycle SHALL both take effect.
REQ-025 BYPASS=1: when a read address equals an address being written this cycle (nonzero), rd_data SHALL return the merged post-write value (link value if link wins); BYPASS=0: old value.
REQ-026 dbg_data SHALL always return the stored (pre-edge) value, never forwarded.
REQ-027 One busy bit per register; busy_set sets it on the edge; any wr_en or link_en write to that address clears it.
REQ-028 Simultaneous busy_set and clearing write to the same address SHALL leave the bit set (new load wins).
REQ-029 busy_set to an already-busy register SHALL leave pending_cnt unchanged.
REQ-030 pending_cnt SHALL equal the population count of busy bits after each edge; it SHALL never wrap (max 2**ADDR_W-1).
REQ-031 stall SHALL be 1 iff rd_addr1 or rd_addr2 (nonzero) is busy and is not cleared by a write in the same cycle.
REQ-032 Read outputs and stall SHALL be purely combinational (zero latency); writes and busy changes are visible after one edge.

Reset
REQ-033 While reset=1, all registers, busy bits and pending_cnt SHALL be 0 regardless of clk; rd_data1/2, dbg_data = 0, stall = 0.
REQ-034 Writes, link writes and busy_set asserted while reset=1 SHALL have no effect; reset mid-write SHALL discard that write.

Verification
REQ-035 Reset, then read all addresses -> every rd_data and dbg_data = 0, stall=0, pending_cnt=0.
REQ-036 Write 0xAABBCCDD to r5 with wr_be=4'b1111, then wr_data=0x11223344, wr_be=4'b0101 -> r5 = 0xAA22CC44.
REQ-037 Same cycle: wr_en to r31 with 0x1234, link_en with 0x0040_0008, rd_addr1=31 -> rd_data1=0x0040_0008 (BYPASS=1), r31=0x0040_0008 after edge.
REQ-038 busy_set r7, next cycle rd_addr2=7 -> stall=1, pending_cnt=1; write r7 while reading -> stall=0 that cycle, pending_cnt=0 after edge.
REQ-039 busy_set r9 and wr_en to r9 in same cycle -> busy bit stays set, pending_cnt=1; busy_set r0 -> pending_cnt unchanged.
REQ-040 Assert reset asynchronously between edges with r3 busy and nonzero -> r3 read = 0, stall=0, pending_cnt=0 immediately.
